// File: rtl/airlock_ctrl_param.sv
// Airlock interlock controller. One FSM handles the chamber pressure state,
// the outer and inner ports and the fill/evacuate countdown. A separate
// countdown handles arrival/departure docking.
// Optional feature: define AIRLOCK_ABORT_EN to let abort reverse a running
// fill/evacuate. Without it, abort is ignored.
module airlock_ctrl_param #(
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FILL_TICKS = 7,
  parameter int unsigned EVAC_TICKS = 8,
  parameter int unsigned DOCK_TICKS = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             arrive_req_i,
  input  logic             depart_req_i,
  input  logic             outer_toggle_i,
  input  logic             inner_toggle_i,
  input  logic             fill_req_i,
  input  logic             evac_req_i,
  input  logic             abort_i,
  output logic             outer_open_o,
  output logic             inner_open_o,
  output logic             pressurized_o,
  output logic             evacuated_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] proc_count_o,
  output logic [CNT_W-1:0] dock_count_o,
  output logic             arrive_led_o,
  output logic             depart_led_o,
  output logic             reject_o
);

  typedef enum logic [1:0] {
    S_EVACUATED,
    S_FILLING,
    S_PRESSURIZED,
    S_EVACUATING
  } state_t;

  localparam logic [CNT_W-1:0] FILL_LD = CNT_W'(FILL_TICKS);
  localparam logic [CNT_W-1:0] EVAC_LD = CNT_W'(EVAC_TICKS);
  localparam logic [CNT_W-1:0] DOCK_LD = CNT_W'(DOCK_TICKS);

  state_t           state_q, state_d;
  logic             outer_q, outer_d, inner_q, inner_d;
  logic [CNT_W-1:0] proc_q, proc_d, dock_q, dock_d;
  logic             aled_q, aled_d, dled_q, dled_d;
  logic             rej_q, rej_d;

  logic             closed, fill_ok, evac_ok, start_ok, start_bad, busy;
  logic             abort_take;
  logic [CNT_W-1:0] elapsed;

`ifdef AIRLOCK_ABORT_EN
  assign abort_take = abort_i;
`else
  logic abort_unused;
  assign abort_unused = abort_i;
  assign abort_take   = 1'b0;
`endif

  assign closed    = !outer_q && !inner_q;
  assign busy      = (state_q == S_FILLING) || (state_q == S_EVACUATING);
  assign fill_ok   = (state_q == S_EVACUATED) && closed;
  assign evac_ok   = (state_q == S_PRESSURIZED) && closed;
  assign start_ok  = (fill_req_i && fill_ok) || (evac_req_i && evac_ok);
  assign start_bad = (fill_req_i && !fill_ok) || (evac_req_i && !evac_ok);

  // Next-state logic: chamber FSM with abort > start > toggle priority, plus docking countdown.
  always_comb begin
    state_d = state_q;
    outer_d = outer_q;
    inner_d = inner_q;
    proc_d  = proc_q;
    dock_d  = dock_q;
    aled_d  = aled_q;
    dled_d  = dled_q;
    rej_d   = 1'b0;
    elapsed = '0;

    if (abort_take) begin
      // Reversal runs for as long as the process has already run, so the
      // chamber ends up back where it started.
      unique case (state_q)
        S_FILLING: begin
          elapsed = FILL_LD - proc_q;
          state_d = (elapsed == '0) ? S_EVACUATED : S_EVACUATING;
          proc_d  = elapsed;
        end
        S_EVACUATING: begin
          elapsed = EVAC_LD - proc_q;
          state_d = (elapsed == '0) ? S_PRESSURIZED : S_FILLING;
          proc_d  = elapsed;
        end
        default: rej_d = 1'b1;
      endcase
    end else begin
      if (start_ok) begin
        // An accepted start silently drops any same-cycle toggle.
        if (state_q == S_EVACUATED) begin
          state_d = S_FILLING;
          proc_d  = FILL_LD;
        end else begin
          state_d = S_EVACUATING;
          proc_d  = EVAC_LD;
        end
      end else begin
        if (busy && tick_i) begin
          if (proc_q == CNT_W'(1)) begin
            proc_d  = '0;
            state_d = (state_q == S_FILLING) ? S_PRESSURIZED : S_EVACUATED;
          end else begin
            proc_d = proc_q - CNT_W'(1);
          end
        end
        if (outer_toggle_i) begin
          if (state_q == S_EVACUATED) outer_d = !outer_q;
          else                        rej_d   = 1'b1;
        end
        if (inner_toggle_i) begin
          if (state_q == S_PRESSURIZED) inner_d = !inner_q;
          else                          rej_d   = 1'b1;
        end
      end
      if (start_bad) rej_d = 1'b1;
    end

    // Loads only happen at dock_q==0, so they never collide with a decrement.
    if (tick_i && dock_q != '0) begin
      dock_d = dock_q - CNT_W'(1);
      if (dock_q == CNT_W'(1)) begin
        aled_d = 1'b0;
        dled_d = 1'b0;
      end
    end
    if (arrive_req_i) begin
      if (dock_q == '0) begin
        dock_d = DOCK_LD;
        aled_d = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end
    if (depart_req_i) begin
      if (arrive_req_i || dock_q != '0) begin
        rej_d = 1'b1;
      end else begin
        dock_d = DOCK_LD;
        dled_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_EVACUATED;
      outer_q <= 1'b0;
      inner_q <= 1'b0;
      proc_q  <= '0;
      dock_q  <= '0;
      aled_q  <= 1'b0;
      dled_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      outer_q <= outer_d;
      inner_q <= inner_d;
      proc_q  <= proc_d;
      dock_q  <= dock_d;
      aled_q  <= aled_d;
      dled_q  <= dled_d;
      rej_q   <= rej_d;
    end
  end

  assign outer_open_o  = outer_q;
  assign inner_open_o  = inner_q;
  assign pressurized_o = (state_q == S_PRESSURIZED);
  assign evacuated_o   = (state_q == S_EVACUATED);
  assign busy_o        = busy;
  assign proc_count_o  = proc_q;
  assign dock_count_o  = dock_q;
  assign arrive_led_o  = aled_q;
  assign depart_led_o  = dled_q;
  assign reject_o      = rej_q;

endmodule
